// File: rtl/aes_result_fifo_pkg.sv
// Shared AES datapath constants and helpers.
package aes_vp_pkg;

    localparam int unsigned AES_BLK_W      = 128;
    localparam int unsigned RES_FIFO_DEPTH = 4;

    // Per-cycle FIFO operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/aes_result_fifo_if.sv
// AES-result and serializer handshake signals around aes_result_fifo.
interface aes_result_fifo_if
    import aes_vp_pkg::*;
#(
    parameter int unsigned WIDTH = AES_BLK_W
);
    logic             aes_done;
    logic [WIDTH-1:0] aes_result;
    logic             aes_stall;
    logic [WIDTH-1:0] data_data;
    logic             data_empty;
    logic             data_require;

    // Producer/consumer side (AES core + serializer).
    modport master (
        output aes_done,
        output aes_result,
        input  aes_stall,
        input  data_data,
        input  data_empty,
        output data_require
    );

    // FIFO side.
    modport slave (
        input  aes_done,
        input  aes_result,
        output aes_stall,
        output data_data,
        output data_empty,
        input  data_require
    );
endinterface

// File: rtl/aes_result_fifo.sv
// Show-ahead FIFO of completed AES blocks with stall, flush and sticky overflow.
module aes_result_fifo
    import aes_vp_pkg::*;
#(
    parameter int unsigned DEPTH = RES_FIFO_DEPTH,
    parameter int unsigned WIDTH = AES_BLK_W
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_result_fifo_if.slave         bus,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      cnt;

    logic             pop;
    logic             push;
    logic             drop;
    fifo_op_e         op;
    logic [PW:0]      cnt_nxt;

    always_comb begin
        pop     = 1'b0;
        push    = 1'b0;
        drop    = 1'b0;
        cnt_nxt = cnt;

        pop  = bus.data_require && (cnt != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push = bus.aes_done && ((cnt != FULL_CNT) || pop);
        drop = bus.aes_done && (cnt == FULL_CNT) && !pop && !flush;
        op   = fifo_op_e'({pop, push});

        unique case (op)
            OP_PUSH: cnt_nxt = cnt + 1'b1;
            OP_POP:  cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase

        bus.data_empty = (cnt == '0);
        bus.aes_stall  = (cnt == FULL_CNT);
        bus.data_data  = (cnt == '0) ? '0 : mem[rp];
        level          = cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                cnt <= cnt_nxt;
            end
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= bus.aes_result;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            if (drop) $warning("aes_result_fifo: aes_done while stalled, block dropped");
            level_bound: assert (cnt <= FULL_CNT)
                else $error("aes_result_fifo: level %0d exceeds DEPTH", cnt);
        end
    end
`endif

endmodule
